// File: rtl/avl_mm_bridge_if.sv
// Avalon-MM bus bundle between the load/store bridge (master) and the interconnect (slave).
interface avl_mm_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    waitrequest;

  modport master (
    output address, writedata, byteenable, read, write,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, writedata, byteenable, read, write,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avl_mm_bridge.sv
// Registered core-to-Avalon-MM master bridge for the RISC-V load/store stage (32/64-bit).
// Define AVL_MM_BRIDGE_MISALIGN_EN to split word-crossing accesses into two bus beats.
module avl_mm_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data2write,
  input  logic [1:0]            rw,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] data2read,
  output logic                  err,
  avl_mm_bridge_if.master       avl
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OW  = $clog2(NB);
  localparam int BW2 = 2 * NB;

`ifdef AVL_MM_BRIDGE_MISALIGN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t state, next_state;

  logic [2:0]            mode_q;
  logic [OW-1:0]         off_q;
  logic                  is_read;
  logic [3:0]            req_size;
  logic [OW-1:0]         req_off;
  logic [4:0]            req_end;
  logic                  req_cross;
  logic                  req_illegal;
  logic                  base_illegal;
  logic [NB-1:0]         be_first;
  logic [DATA_WIDTH-1:0] raw;
  logic [DATA_WIDTH-1:0] ext;

`ifdef AVL_MM_BRIDGE_MISALIGN_EN
  localparam int OW1 = OW + 1;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [3:0]              q_size;
  logic [4:0]              q_end;
  logic                    q_cross;
  logic [OW:0]             rem;
  logic [NB-1:0]           be_second;
  logic [2*DATA_WIDTH-1:0] cat;
`endif

  always_comb begin
    req_size     = 4'd1 << mode[1:0];
    req_off      = addr[OW-1:0];
    req_end      = 5'(req_off) + 5'(req_size);
    req_cross    = req_end > 5'(NB);
    base_illegal = (rw == 2'b11) || (mode == 3'b111) ||
                   ((DATA_WIDTH == 32) && ((mode == 3'b011) || (mode == 3'b110)));
`ifdef AVL_MM_BRIDGE_MISALIGN_EN
    req_illegal  = base_illegal;
`else
    req_illegal  = base_illegal || req_cross;
`endif
    be_first     = NB'(((BW2'(1) << req_size) - BW2'(1)) << req_off);
  end

  // Beat-0 lanes sit below beat-1 lanes, so one shift by the offset assembles either case.
`ifdef AVL_MM_BRIDGE_MISALIGN_EN
  always_comb begin
    q_size    = 4'd1 << mode_q[1:0];
    q_end     = 5'(off_q) + 5'(q_size);
    q_cross   = q_end > 5'(NB);
    rem       = OW1'(NB) - OW1'(off_q);
    be_second = (NB'(1) << (q_end - 5'(NB))) - NB'(1);
    cat       = (state == BEAT1) ? {avl.readdata, lo_q} : {{DATA_WIDTH{1'b0}}, avl.readdata};
    raw       = DATA_WIDTH'(cat >> {off_q, 3'b000});
  end
`else
  always_comb begin
    raw = avl.readdata >> {off_q, 3'b000};
  end
`endif

  always_comb begin
    case (mode_q)
      3'b000:  ext = DATA_WIDTH'($signed(raw[7:0]));
      3'b001:  ext = DATA_WIDTH'($signed(raw[15:0]));
      3'b010:  ext = DATA_WIDTH'($signed(raw[31:0]));
      3'b011:  ext = raw;
      3'b100:  ext = DATA_WIDTH'(raw[7:0]);
      3'b101:  ext = DATA_WIDTH'(raw[15:0]);
      3'b110:  ext = DATA_WIDTH'(raw[31:0]);
      default: ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (rw != 2'b00) next_state = req_illegal ? DONE : BEAT0;
      BEAT0: begin
        if (!avl.waitrequest) begin
`ifdef AVL_MM_BRIDGE_MISALIGN_EN
          next_state = q_cross ? BEAT1 : DONE;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef AVL_MM_BRIDGE_MISALIGN_EN
      BEAT1: if (!avl.waitrequest) next_state = DONE;
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall = reset && (state != DONE) && ((state != IDLE) || (rw != 2'b00));
  end

  // Avalon outputs are registered and change only on capture or on a beat being accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      avl.address    <= '0;
      avl.writedata  <= '0;
      avl.byteenable <= '0;
      avl.read       <= 1'b0;
      avl.write      <= 1'b0;
      err            <= 1'b0;
      data2read      <= '0;
      mode_q         <= '0;
      off_q          <= '0;
      is_read        <= 1'b0;
`ifdef AVL_MM_BRIDGE_MISALIGN_EN
      data_q         <= '0;
      lo_q           <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (rw != 2'b00) begin
            mode_q  <= mode;
            off_q   <= req_off;
            is_read <= rw[1];
`ifdef AVL_MM_BRIDGE_MISALIGN_EN
            data_q  <= data2write;
`endif
            if (req_illegal) begin
              err       <= 1'b1;
              data2read <= '0;
            end else begin
              avl.address    <= {addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
              avl.byteenable <= be_first;
              avl.writedata  <= data2write << {req_off, 3'b000};
              avl.read       <= rw[1];
              avl.write      <= rw[0];
            end
          end
        end
        BEAT0: begin
          if (!avl.waitrequest) begin
`ifdef AVL_MM_BRIDGE_MISALIGN_EN
            lo_q <= avl.readdata;
            if (q_cross) begin
              avl.address    <= avl.address + ADDR_WIDTH'(NB);
              avl.byteenable <= be_second;
              avl.writedata  <= data_q >> {rem, 3'b000};
            end else begin
              avl.read  <= 1'b0;
              avl.write <= 1'b0;
              data2read <= is_read ? ext : '0;
            end
`else
            avl.read  <= 1'b0;
            avl.write <= 1'b0;
            data2read <= is_read ? ext : '0;
`endif
          end
        end
`ifdef AVL_MM_BRIDGE_MISALIGN_EN
        BEAT1: begin
          if (!avl.waitrequest) begin
            avl.read  <= 1'b0;
            avl.write <= 1'b0;
            data2read <= is_read ? ext : '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_avl_mm_bridge.sv
// Scoreboard bench for avl_mm_bridge: a 32-bit instance with a waitstate slave model and
// a 64-bit instance; bus beats and core responses are checked by independent monitors.
module tb_avl_mm_bridge;
  typedef struct { logic [63:0] data; logic err; int stalls; } resp_t;
  typedef struct { logic [31:0] address; logic [7:0] be; logic [63:0] wdata; logic rd; logic wr; } beat_t;
  typedef struct { int waits; logic [31:0] rdata; } slave_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mode;
  logic [31:0] addr, data2write, data2read;
  logic [1:0]  rw;
  logic        stall, err;

  logic [2:0]  mode64;
  logic [31:0] addr64;
  logic [63:0] data2write64, data2read64, rdata64;
  logic [1:0]  rw64;
  logic        stall64, err64;

  int errors = 0;
  int checks = 0;

  resp_t  resp_q[$], resp64_q[$];
  beat_t  beat_q[$], beat64_q[$];
  slave_t slave_q[$];
  resp_t  exp_resp, exp_resp64;
  beat_t  exp_beat, exp_beat64;
  slave_t cur;
  int     wait_left = 0;
  bit     beat_active = 1'b0;
  int     stall_cnt = 0;

  always #5 clk = ~clk;

  avl_mm_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) avl ();
  avl_mm_bridge_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) avl64 ();

  avl_mm_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mode(mode), .addr(addr), .data2write(data2write), .rw(rw),
    .stall(stall), .data2read(data2read), .err(err), .avl(avl)
  );

  avl_mm_bridge #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
    .clk(clk), .reset(reset), .mode(mode64), .addr(addr64), .data2write(data2write64), .rw(rw64),
    .stall(stall64), .data2read(data2read64), .err(err64), .avl(avl64)
  );

  assign avl64.waitrequest = 1'b0;
  assign avl64.readdata    = rdata64;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Slave model: each new beat takes the next entry's wait count and read data.
  always @(posedge clk) begin
    if (beat_active && !avl.waitrequest) beat_active = 1'b0;
    #1;
    if (avl.read || avl.write) begin
      if (!beat_active) begin
        if (slave_q.size() > 0) cur = slave_q.pop_front();
        else cur = '{0, 32'h0};
        wait_left   = cur.waits;
        beat_active = 1'b1;
      end else if (wait_left > 0) begin
        wait_left--;
      end
      avl.waitrequest = (wait_left > 0);
      avl.readdata    = cur.rdata;
    end else begin
      beat_active     = 1'b0;
      avl.waitrequest = 1'b0;
      avl.readdata    = '0;
    end
  end

  always @(negedge clk) begin
    if (reset && (avl.read || avl.write)) begin
      if (beat_q.size() == 0) begin
        check_output("unexpected_strobe", {62'd0, avl.read, avl.write}, 64'd0);
      end else begin
        exp_beat = beat_q[0];
        check_output("bus_address", 64'(avl.address), 64'(exp_beat.address));
        check_output("bus_byteenable", 64'(avl.byteenable), 64'(exp_beat.be));
        check_output("bus_read", 64'(avl.read), 64'(exp_beat.rd));
        check_output("bus_write", 64'(avl.write), 64'(exp_beat.wr));
        if (exp_beat.wr)
          check_output("bus_writedata", 64'(avl.writedata) & lane_mask(exp_beat.be),
                       exp_beat.wdata & lane_mask(exp_beat.be));
        if (!avl.waitrequest) void'(beat_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      stall_cnt = 0;
    end else if (rw != 2'b00) begin
      if (stall) begin
        stall_cnt++;
      end else begin
        if (resp_q.size() == 0) begin
          check_output("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_resp = resp_q.pop_front();
          check_output("data2read", 64'(data2read), exp_resp.data);
          check_output("err", 64'(err), 64'(exp_resp.err));
          check_output("stall_cycles", 64'(stall_cnt), 64'(exp_resp.stalls));
        end
        stall_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && (avl64.read || avl64.write)) begin
      if (beat64_q.size() == 0) begin
        check_output("unexpected_strobe64", {62'd0, avl64.read, avl64.write}, 64'd0);
      end else begin
        exp_beat64 = beat64_q.pop_front();
        check_output("bus64_address", 64'(avl64.address), 64'(exp_beat64.address));
        check_output("bus64_byteenable", 64'(avl64.byteenable), 64'(exp_beat64.be));
      end
    end
    if (reset && (rw64 != 2'b00) && !stall64) begin
      if (resp64_q.size() == 0) begin
        check_output("unexpected_done64", 64'd1, 64'd0);
      end else begin
        exp_resp64 = resp64_q.pop_front();
        check_output("data2read64", data2read64, exp_resp64.data);
        check_output("err64", 64'(err64), 64'(exp_resp64.err));
      end
    end
  end

  task automatic add_beat(input logic [31:0] a, input logic [7:0] be, input logic [63:0] wd,
                          input logic rd, input logic wr, input int waits, input logic [31:0] rdata);
    beat_q.push_back('{a, be, wd, rd, wr});
    slave_q.push_back('{waits, rdata});
  endtask

  task automatic apply_stimulus(input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] r, input logic [31:0] exp_data,
                                input logic exp_err, input int exp_stalls);
    bit seen = 1'b0;
    resp_q.push_back('{64'(exp_data), exp_err, exp_stalls});
    @(posedge clk); #1;
    mode = m; addr = a; data2write = wd; rw = r;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!stall) begin seen = 1'b1; break; end
    end
    if (!seen) check_output("stall_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    rw = 2'b00;
  endtask

  task automatic apply64(input logic [2:0] m, input logic [31:0] a, input logic [63:0] rdata,
                         input logic [31:0] exp_addr, input logic [7:0] exp_be,
                         input logic [63:0] exp_data, input logic exp_err);
    bit seen = 1'b0;
    if (!exp_err) beat64_q.push_back('{exp_addr, exp_be, 64'd0, 1'b1, 1'b0});
    resp64_q.push_back('{exp_data, exp_err, 0});
    @(posedge clk); #1;
    mode64 = m; addr64 = a; rdata64 = rdata; rw64 = 2'b10;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!stall64) begin seen = 1'b1; break; end
    end
    if (!seen) check_output("stall64_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    rw64 = 2'b00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0; mode = 3'b010; addr = 32'h100; data2write = '0; rw = 2'b10;
    mode64 = '0; addr64 = '0; data2write64 = '0; rw64 = 2'b00; rdata64 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_address", 64'(avl.address), 64'd0);
    check_output("rst_byteenable", 64'(avl.byteenable), 64'd0);
    check_output("rst_writedata", 64'(avl.writedata), 64'd0);
    check_output("rst_strobes", {62'd0, avl.read, avl.write}, 64'd0);
    check_output("rst_err", 64'(err), 64'd0);
    check_output("rst_data2read", 64'(data2read), 64'd0);
    check_output("rst_stall", 64'(stall), 64'd0);
    reset = 1'b1; rw = 2'b00;

    add_beat(32'h100, 8'b1111, 64'd0, 1'b1, 1'b0, 0, 32'h80FF_1234);
    apply_stimulus(3'b010, 32'h100, 32'h0, 2'b10, 32'h80FF_1234, 1'b0, 2);

    add_beat(32'h100, 8'b1000, 64'hAB00_0000, 1'b0, 1'b1, 3, 32'h0);
    apply_stimulus(3'b000, 32'h103, 32'h0000_00AB, 2'b01, 32'h0, 1'b0, 5);

    add_beat(32'h100, 8'b0100, 64'd0, 1'b1, 1'b0, 0, 32'h0085_0000);
    apply_stimulus(3'b000, 32'h102, 32'h0, 2'b10, 32'hFFFF_FF85, 1'b0, 2);

    add_beat(32'h100, 8'b0100, 64'd0, 1'b1, 1'b0, 0, 32'h0085_0000);
    apply_stimulus(3'b100, 32'h102, 32'h0, 2'b10, 32'h0000_0085, 1'b0, 2);
    repeat (2) @(posedge clk);
    #1;
    check_output("data2read_hold", 64'(data2read), 64'h85);

    add_beat(32'h100, 8'b1100, 64'd0, 1'b1, 1'b0, 0, 32'h9ABC_0000);
    apply_stimulus(3'b001, 32'h102, 32'h0, 2'b10, 32'hFFFF_9ABC, 1'b0, 2);

    add_beat(32'h004, 8'b1100, 64'd0, 1'b1, 1'b0, 2, 32'hF00D_0000);
    apply_stimulus(3'b101, 32'h006, 32'h0, 2'b10, 32'h0000_F00D, 1'b0, 4);

    add_beat(32'h200, 8'b1100, 64'hBEEF_0000, 1'b0, 1'b1, 0, 32'h0);
    apply_stimulus(3'b001, 32'h202, 32'h1234_BEEF, 2'b01, 32'h0, 1'b0, 2);

    add_beat(32'h204, 8'b1111, 64'hDEAD_BEEF, 1'b0, 1'b1, 1, 32'h0);
    apply_stimulus(3'b010, 32'h204, 32'hDEAD_BEEF, 2'b01, 32'h0, 1'b0, 3);

`ifdef AVL_MM_BRIDGE_MISALIGN_EN
    add_beat(32'h0FC, 8'b1100, 64'd0, 1'b1, 1'b0, 0, 32'hBEEF_1111);
    add_beat(32'h100, 8'b0011, 64'd0, 1'b1, 1'b0, 0, 32'h2222_CAFE);
    apply_stimulus(3'b010, 32'h0FE, 32'h0, 2'b10, 32'hCAFE_BEEF, 1'b0, 3);
    add_beat(32'h1FC, 8'b1000, 64'hB200_0000, 1'b0, 1'b1, 1, 32'h0);
    add_beat(32'h200, 8'b0001, 64'h0000_00A1, 1'b0, 1'b1, 2, 32'h0);
    apply_stimulus(3'b001, 32'h1FF, 32'h0000_A1B2, 2'b01, 32'h0, 1'b0, 6);
`else
    apply_stimulus(3'b010, 32'h0FE, 32'h0, 2'b10, 32'h0, 1'b1, 1);
    apply_stimulus(3'b001, 32'h1FF, 32'h0000_A1B2, 2'b01, 32'h0, 1'b1, 1);
`endif

    apply_stimulus(3'b010, 32'h100, 32'h0, 2'b11, 32'h0, 1'b1, 1);
    apply_stimulus(3'b111, 32'h100, 32'h0, 2'b10, 32'h0, 1'b1, 1);
    apply_stimulus(3'b011, 32'h108, 32'h0, 2'b10, 32'h0, 1'b1, 1);
    apply_stimulus(3'b110, 32'h108, 32'h0, 2'b10, 32'h0, 1'b1, 1);

    // Abort a read that is stuck in wait states.
    add_beat(32'h300, 8'b1111, 64'd0, 1'b1, 1'b0, 50, 32'h0);
    @(posedge clk); #1;
    mode = 3'b010; addr = 32'h300; rw = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_output("abort_read", 64'(avl.read), 64'd0);
    check_output("abort_write", 64'(avl.write), 64'd0);
    check_output("abort_stall", 64'(stall), 64'd0);
    check_output("abort_err", 64'(err), 64'd0);
    check_output("abort_data2read", 64'(data2read), 64'd0);
    reset = 1'b1; rw = 2'b00;
    beat_q.delete();

    add_beat(32'h104, 8'b1111, 64'd0, 1'b1, 1'b0, 0, 32'h1357_9BDF);
    apply_stimulus(3'b010, 32'h104, 32'h0, 2'b10, 32'h1357_9BDF, 1'b0, 2);

    apply64(3'b011, 32'h08, 64'h0123_4567_89AB_CDEF, 32'h08, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
    apply64(3'b010, 32'h0C, 64'h8000_0001_0000_0000, 32'h08, 8'hF0, 64'hFFFF_FFFF_8000_0001, 1'b0);
    apply64(3'b110, 32'h0C, 64'h8000_0001_0000_0000, 32'h08, 8'hF0, 64'h0000_0000_8000_0001, 1'b0);
    apply64(3'b000, 32'h0F, 64'hC300_0000_0000_0000, 32'h08, 8'h80, 64'hFFFF_FFFF_FFFF_FFC3, 1'b0);
    apply64(3'b101, 32'h12, 64'h0000_0000_9ABC_0000, 32'h10, 8'h0C, 64'h0000_0000_0000_9ABC, 1'b0);
    apply64(3'b111, 32'h10, 64'h0, 32'h0, 8'h00, 64'h0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check_output("resp_q_drained", 64'(resp_q.size()), 64'd0);
    check_output("beat_q_drained", 64'(beat_q.size()), 64'd0);
    check_output("resp64_q_drained", 64'(resp64_q.size()), 64'd0);
    check_output("beat64_q_drained", 64'(beat64_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
